// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the raster timing generator:
//   - CNT_W_DEFAULT      default counter / coordinate width
//   - vga_mode_t         one axis worth of timing {display, front, sync, back}
//   - VGA_640X480_H/V    640x480@60 horizontal and vertical timing
//   - SYNC_ACTIVE_LOW/HIGH  sync polarity selectors
//   - vga_sync_t         bundle of the signals that travel through the
//                        optional alignment delay line
//   - mode_total()       total length of one axis (line or frame)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int CNT_W_DEFAULT = 11;

   typedef struct packed {
      int display;
      int front;
      int sync;
      int back;
   } vga_mode_t;

   localparam vga_mode_t VGA_640X480_H = '{display: 640, front: 16, sync: 96, back: 48};
   localparam vga_mode_t VGA_640X480_V = '{display: 480, front: 10, sync: 2,  back: 33};

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } vga_sync_t;

   function automatic int mode_total(input vga_mode_t m);
      return m.display + m.front + m.sync + m.back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One axis of the raster: counts 0..total-1 while ce is high and decodes the
// regions of that axis from the current (pre-increment) count.
// Ports:
//   clk, reset   clock, synchronous active-low reset (count -> 0)
//   ce           advance enable
//   count        current position on this axis
//   wrap         count is at the last position (next ce returns to 0)
//   active       count is inside the display region
//   sync_win     count is inside the sync pulse window
// ---------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int        CNT_W = CNT_W_DEFAULT,
   parameter vga_mode_t MODE  = VGA_640X480_H
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             active,
   output logic             sync_win
);

   localparam logic [CNT_W-1:0] LAST       = CNT_W'(mode_total(MODE) - 1);
   localparam logic [CNT_W-1:0] DISP_END   = CNT_W'(MODE.display);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(MODE.display + MODE.front);
   localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(MODE.display + MODE.front + MODE.sync);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (ce) begin
         count_d = wrap ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign wrap     = (count_q == LAST);
   assign active   = (count_q < DISP_END);
   assign sync_win = (count_q >= SYNC_START) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA/DVI raster timing generator. Two chained axis counters
// (horizontal on pix_ce, vertical on pix_ce at end of line) feed a registered
// decode stage; all outputs change only on pix_ce cycles and lag the counters
// by one pix_ce. hsync/vsync/de can be delayed a further PIPE_DLY pix_ce
// stages to line up with a downstream pixel pipeline; x/y and the start
// pulses are never delayed.
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   pix_ce       pixel clock enable
//   hsync/vsync  sync outputs, active level H_SYNC_POL / V_SYNC_POL
//   de           display enable
//   x, y         active-area coordinates, 0 outside the active area
//   line_start   one-clk pulse at h_cnt==0
//   frame_start  one-clk pulse at h_cnt==0 && v_cnt==0
//   frame_cnt    completed-frame counter
// Configuration macro:
//   VGA_FRAME_CNT_EN  when defined, frame_cnt counts frames (mod 2^16);
//                     otherwise frame_cnt is tied to zero.
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEFAULT,
   parameter int H_DISPLAY  = VGA_640X480_H.display,
   parameter int H_FRONT    = VGA_640X480_H.front,
   parameter int H_SYNC     = VGA_640X480_H.sync,
   parameter int H_BACK     = VGA_640X480_H.back,
   parameter int V_DISPLAY  = VGA_640X480_V.display,
   parameter int V_FRONT    = VGA_640X480_V.front,
   parameter int V_SYNC     = VGA_640X480_V.sync,
   parameter int V_BACK     = VGA_640X480_V.back,
   parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int PIPE_DLY   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start,
   output logic [15:0]      frame_cnt
);

   localparam vga_mode_t H_MODE = '{display: H_DISPLAY, front: H_FRONT, sync: H_SYNC, back: H_BACK};
   localparam vga_mode_t V_MODE = '{display: V_DISPLAY, front: V_FRONT, sync: V_SYNC, back: V_BACK};

   localparam vga_sync_t SYNC_IDLE = '{hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL, de: 1'b0};

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_wrap, v_wrap;
   logic             h_active, v_active;
   logic             h_sync_win, v_sync_win;
   logic             v_ce;

   // The vertical axis only moves on the pix_ce that ends a line, so both
   // counters wrap on the very same edge at the end of a frame.
   assign v_ce = pix_ce & h_wrap;

   vga_axis_counter #(
      .CNT_W (CNT_W),
      .MODE  (H_MODE)
   ) u_h_axis (
      .clk      (clk),
      .reset    (reset),
      .ce       (pix_ce),
      .count    (h_cnt),
      .wrap     (h_wrap),
      .active   (h_active),
      .sync_win (h_sync_win)
   );

   vga_axis_counter #(
      .CNT_W (CNT_W),
      .MODE  (V_MODE)
   ) u_v_axis (
      .clk      (clk),
      .reset    (reset),
      .ce       (v_ce),
      .count    (v_cnt),
      .wrap     (v_wrap),
      .active   (v_active),
      .sync_win (v_sync_win)
   );

   // Stage 0 of sync_pipe is the mandatory output register; stages
   // 1..PIPE_DLY are the optional alignment delay, all advancing on pix_ce.
   vga_sync_t [PIPE_DLY:0] sync_pipe_q, sync_pipe_d;
   vga_sync_t              sync_now;
   logic                   de_now;
   logic [CNT_W-1:0]       x_q, x_d, y_q, y_d;
   logic                   line_start_q, line_start_d;
   logic                   frame_start_q, frame_start_d;

   always_comb begin
      de_now         = h_active & v_active;
      sync_now.hsync = h_sync_win ? H_SYNC_POL : ~H_SYNC_POL;
      sync_now.vsync = v_sync_win ? V_SYNC_POL : ~V_SYNC_POL;
      sync_now.de    = de_now;

      sync_pipe_d   = sync_pipe_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (pix_ce) begin
         sync_pipe_d[0] = sync_now;
         for (int i = 1; i <= PIPE_DLY; i++) begin
            sync_pipe_d[i] = sync_pipe_q[i-1];
         end
         x_d           = de_now ? h_cnt : '0;
         y_d           = de_now ? v_cnt : '0;
         line_start_d  = (h_cnt == '0);
         frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_pipe_q   <= {(PIPE_DLY+1){SYNC_IDLE}};
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         sync_pipe_q   <= sync_pipe_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = sync_pipe_q[PIPE_DLY].hsync;
   assign vsync       = sync_pipe_q[PIPE_DLY].vsync;
   assign de          = sync_pipe_q[PIPE_DLY].de;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // A frame is complete on the pix_ce where both axes wrap together.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (v_ce && v_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;
   assign frame_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Drives two generators from the same clock/reset/pix_ce:
//   dut_def  default 640x480 timing, no delay, active-low syncs
//   dut_sm   tiny 15x8 raster, PIPE_DLY=2, active-high hsync, so whole
//            frames fit in a short run
// Expected values are hand-derived from the timing parameters below.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset;
   logic pix_ce;

   logic        def_hsync, def_vsync, def_de, def_line_start, def_frame_start;
   logic [10:0] def_x, def_y;
   logic [15:0] def_frame_cnt;

   logic        sm_hsync, sm_vsync, sm_de, sm_line_start, sm_frame_start;
   logic [10:0] sm_x, sm_y;
   logic [15:0] sm_frame_cnt;

   int errors = 0;
   int checks = 0;

`ifdef VGA_FRAME_CNT_EN
   localparam bit FCNT_EN = 1'b1;
`else
   localparam bit FCNT_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   vga_timing_gen dut_def (
      .clk         (clk),
      .reset       (reset),
      .pix_ce      (pix_ce),
      .hsync       (def_hsync),
      .vsync       (def_vsync),
      .de          (def_de),
      .x           (def_x),
      .y           (def_y),
      .line_start  (def_line_start),
      .frame_start (def_frame_start),
      .frame_cnt   (def_frame_cnt)
   );

   // Small raster: line = 8+2+3+2 = 15, frame = 4+1+2+1 = 8 lines = 120 pix_ce.
   vga_timing_gen #(
      .H_DISPLAY  (8),
      .H_FRONT    (2),
      .H_SYNC     (3),
      .H_BACK     (2),
      .V_DISPLAY  (4),
      .V_FRONT    (1),
      .V_SYNC     (2),
      .V_BACK     (1),
      .H_SYNC_POL (1'b1),
      .PIPE_DLY   (2)
   ) dut_sm (
      .clk         (clk),
      .reset       (reset),
      .pix_ce      (pix_ce),
      .hsync       (sm_hsync),
      .vsync       (sm_vsync),
      .de          (sm_de),
      .x           (sm_x),
      .y           (sm_y),
      .line_start  (sm_line_start),
      .frame_start (sm_frame_start),
      .frame_cnt   (sm_frame_cnt)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drives the inputs for one clock, then returns 1 time unit after the edge
   // so outputs are sampled clear of the active edge.
   task automatic applyStimulus(input logic rst_n, input logic ce);
      reset  = rst_n;
      pix_ce = ce;
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case something stalls the stimulus.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int def_de_cnt = 0, def_hs_cnt = 0, def_hs_first = -1, def_hs_last = -1;
      int sm_de_cnt = 0, sm_hs_cnt = 0, sm_hs_first = -1, sm_vs_cnt = 0, sm_vs_first = -1;
      int def_ls[$];
      int sm_fs[$];
      int hold_viol = 0, idle_pulse = 0;
      logic [31:0] prev_def, prev_sm;
      logic found;

      // ---------------- reset state ----------------
      reset  = 1'b0;
      pix_ce = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b1);
      checkOutput("rst_def_x",      def_x, 0);
      checkOutput("rst_def_y",      def_y, 0);
      checkOutput("rst_def_de",     def_de, 0);
      checkOutput("rst_def_hsync",  def_hsync, 1);
      checkOutput("rst_def_vsync",  def_vsync, 1);
      checkOutput("rst_def_ls",     def_line_start, 0);
      checkOutput("rst_def_fs",     def_frame_start, 0);
      checkOutput("rst_def_fcnt",   def_frame_cnt, 0);
      checkOutput("rst_sm_hsync",   sm_hsync, 0);
      checkOutput("rst_sm_vsync",   sm_vsync, 1);
      checkOutput("rst_sm_de",      sm_de, 0);
      checkOutput("rst_sm_fcnt",    sm_frame_cnt, 0);

      // ---------------- continuous run, pix_ce=1 ----------------
      for (int k = 1; k <= 1600; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (k == 1) begin
            checkOutput("first_def_x",   def_x, 0);
            checkOutput("first_def_y",   def_y, 0);
            checkOutput("first_def_de",  def_de, 1);
            checkOutput("first_def_fs",  def_frame_start, 1);
            checkOutput("first_def_ls",  def_line_start, 1);
            checkOutput("first_def_hs",  def_hsync, 1);
            checkOutput("first_sm_fs",   sm_frame_start, 1);
            checkOutput("first_sm_de",   sm_de, 0);
            checkOutput("first_sm_hs",   sm_hsync, 0);
         end
         if (k == 2) begin
            checkOutput("second_def_x",  def_x, 1);
            checkOutput("second_def_ls", def_line_start, 0);
            checkOutput("second_def_fs", def_frame_start, 0);
            checkOutput("second_sm_de",  sm_de, 0);
         end
         if (k == 3) begin
            checkOutput("lag_sm_de",     sm_de, 1);
            checkOutput("lag_sm_x",      sm_x, 2);
         end
         if (k == 121) begin
            checkOutput("sm_fcnt_one",   sm_frame_cnt, FCNT_EN ? 1 : 0);
         end
         if (k == 801) begin
            checkOutput("line1_def_y",   def_y, 1);
            checkOutput("line1_def_x",   def_x, 0);
            checkOutput("line1_def_de",  def_de, 1);
         end
         if (k <= 800) begin
            if (def_de) def_de_cnt++;
            if (!def_hsync) begin
               def_hs_cnt++;
               if (def_hs_first < 0) def_hs_first = k;
               def_hs_last = k;
            end
         end
         if (k <= 120) begin
            if (sm_de) sm_de_cnt++;
            if (sm_hsync) begin
               sm_hs_cnt++;
               if (sm_hs_first < 0) sm_hs_first = k;
            end
            if (!sm_vsync) begin
               sm_vs_cnt++;
               if (sm_vs_first < 0) sm_vs_first = k;
            end
         end
         if (def_line_start) def_ls.push_back(k);
         if (sm_frame_start) sm_fs.push_back(k);
      end
      checkOutput("def_de_per_line",   def_de_cnt, 640);
      checkOutput("def_hs_width",      def_hs_cnt, 96);
      checkOutput("def_hs_first_edge", def_hs_first, 657);
      checkOutput("def_hs_last_edge",  def_hs_last, 752);
      checkOutput("def_ls_count",      def_ls.size(), 2);
      checkOutput("def_line_period",   def_ls[1] - def_ls[0], 800);
      checkOutput("def_fcnt_no_wrap",  def_frame_cnt, 0);
      checkOutput("sm_de_per_frame",   sm_de_cnt, 32);
      checkOutput("sm_hs_per_frame",   sm_hs_cnt, 24);
      checkOutput("sm_hs_first_edge",  sm_hs_first, 13);
      checkOutput("sm_vs_per_frame",   sm_vs_cnt, 30);
      checkOutput("sm_vs_first_edge",  sm_vs_first, 78);
      checkOutput("sm_fs_count",       sm_fs.size(), 14);
      checkOutput("sm_frame_period",   sm_fs[1] - sm_fs[0], 120);
      checkOutput("sm_fcnt_13",        sm_frame_cnt, FCNT_EN ? 13 : 0);

      // ---------------- pix_ce toggling every clk ----------------
      repeat (2) applyStimulus(1'b0, 1'b1);
      def_ls.delete();
      sm_fs.delete();
      prev_def = '0;
      prev_sm  = '0;
      for (int c = 0; c < 1700; c++) begin
         applyStimulus(1'b1, (c % 2) == 0);
         if ((c % 2) == 1) begin
            if ({def_x, def_y, def_de, def_hsync, def_vsync} != prev_def[24:0]) hold_viol++;
            if ({sm_x, sm_y, sm_de, sm_hsync, sm_vsync} != prev_sm[24:0]) hold_viol++;
            if (def_line_start || def_frame_start || sm_line_start || sm_frame_start) idle_pulse++;
         end
         prev_def = {7'd0, def_x, def_y, def_de, def_hsync, def_vsync};
         prev_sm  = {7'd0, sm_x, sm_y, sm_de, sm_hsync, sm_vsync};
         if (def_line_start) def_ls.push_back(c);
         if (sm_frame_start) sm_fs.push_back(c);
      end
      checkOutput("ce_hold_violations", hold_viol, 0);
      checkOutput("ce_idle_pulses",     idle_pulse, 0);
      checkOutput("ce_sm_fs_count",     sm_fs.size(), 8);
      checkOutput("ce_sm_frame_clks",   sm_fs[1] - sm_fs[0], 240);
      checkOutput("ce_def_line_clks",   def_ls[1] - def_ls[0], 1600);

      // ---------------- mid-frame reset ----------------
      applyStimulus(1'b0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (sm_x == 11'd5 && sm_y == 11'd2) found = 1'b1;
      end
      checkOutput("reach_sm_5_2",     found, 1);
      checkOutput("reach_def_x",      def_x, 35);
      applyStimulus(1'b0, 1'b0);
      checkOutput("mid_rst_sm_x",     sm_x, 0);
      checkOutput("mid_rst_sm_y",     sm_y, 0);
      checkOutput("mid_rst_sm_de",    sm_de, 0);
      checkOutput("mid_rst_sm_hs",    sm_hsync, 0);
      checkOutput("mid_rst_sm_vs",    sm_vsync, 1);
      checkOutput("mid_rst_sm_fcnt",  sm_frame_cnt, 0);
      checkOutput("mid_rst_def_x",    def_x, 0);
      checkOutput("mid_rst_def_hs",   def_hsync, 1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("idle_sm_fs",       sm_frame_start, 0);
      checkOutput("idle_sm_x",        sm_x, 0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("restart_sm_x",     sm_x, 0);
      checkOutput("restart_sm_y",     sm_y, 0);
      checkOutput("restart_sm_fs",    sm_frame_start, 1);
      checkOutput("restart_sm_ls",    sm_line_start, 1);
      checkOutput("restart_def_fs",   def_frame_start, 1);
      checkOutput("restart_def_de",   def_de, 1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("restart_sm_x1",    sm_x, 1);
      checkOutput("restart_sm_fs0",   sm_frame_start, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
